// File: rtl/ss_seq_if.sv
// ss_seq_if: save-state mapper bus plus buffer RAM port of the save-state sequencer
interface ss_seq_if;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_dout;
  logic [7:0] ss_rdat;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdat;
  logic       mem_we;
  logic [7:0] mem_rdat;
  modport master(output ss_act, ss_we, ss_addr, ss_dout, mem_addr, mem_wdat, mem_we,
                 input ss_rdat, mem_rdat);
  modport slave(input ss_act, ss_we, ss_addr, ss_dout, mem_addr, mem_wdat, mem_we,
                output ss_rdat, mem_rdat);
endinterface

// File: rtl/ss_seq_ctrl.sv
// ss_seq_ctrl: save/load sequencer copying mapper registers to and from a buffer RAM
module ss_seq_ctrl #(
  parameter int REG_CNT  = 16,
  parameter int IDX_ADDR = 127,
  parameter int SETTLE   = 2,
  parameter int M2_TMO   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  ss_seq_if.master   bus
);
  localparam logic [3:0] IDLE = 4'd0, S_ADDR = 4'd1, S_WAIT = 4'd2, S_CAP = 4'd3,
                         L_IDX = 4'd4, L_CHK = 4'd5, L_RD = 4'd6, L_WFALL = 4'd7,
                         L_WRISE = 4'd8, L_GAP = 4'd9, DONE = 4'd10, ERR = 4'd11;
  localparam int IDX_WAIT = SETTLE > 1 ? SETTLE : 1;
  localparam int TW = $clog2(M2_TMO + 1);
  localparam logic [7:0] LAST = 8'(REG_CNT - 1);
  localparam logic [7:0] IDX = 8'(IDX_ADDR);
  localparam logic [15:0] SW = 16'(SETTLE - 1);
  localparam logic [15:0] IW = 16'(IDX_WAIT - 1);
  localparam logic [TW-1:0] TMAX = TW'(M2_TMO - 1);
  logic [3:0]    state;
  logic [7:0]    addr;
  logic [7:0]    dout;
  logic [15:0]   cnt;
  logic [TW-1:0] tmo;
  logic [2:0]    m2_s;
  logic          m2_fall;
  logic          m2_rise;
  logic          tmo_hit;
  assign m2_fall = m2_s[2] & ~m2_s[1];
  assign m2_rise = ~m2_s[2] & m2_s[1];
  assign tmo_hit = tmo == TMAX;
  assign busy = !(state inside {IDLE, DONE, ERR});
  assign done = state == DONE;
  assign err = state == ERR;
  assign bus.ss_act = busy;
  assign bus.ss_we = state inside {L_WFALL, L_WRISE};
  assign bus.ss_addr = addr;
  assign bus.ss_dout = dout;
  assign bus.mem_addr = addr;
  assign bus.mem_we = state == S_CAP;
  assign bus.mem_wdat = bus.mem_we ? bus.ss_rdat : 8'h00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr <= 8'h00;
      dout <= 8'h00;
      cnt <= 16'h0000;
      tmo <= '0;
      m2_s <= 3'b000;
      err_code <= 2'b00;
    end else begin
      m2_s <= {m2_s[1:0], m2};
      case (state)
        IDLE: begin
          if (cmd_save || cmd_load) begin
            state <= cmd_save ? S_ADDR : L_IDX;
            addr <= cmd_save ? 8'h00 : IDX;
            cnt <= 16'h0000;
            err_code <= 2'b00;
          end
        end
        S_ADDR: begin
          cnt <= 16'h0000;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == SW) state <= S_CAP;
          else cnt <= cnt + 16'd1;
        end
        S_CAP: begin
          state <= addr == IDX ? DONE : S_ADDR;
          addr <= addr == LAST ? IDX : addr + 8'd1;
        end
        L_IDX: begin
          if (cnt == IW) state <= L_CHK;
          else cnt <= cnt + 16'd1;
        end
        L_CHK: begin
          if (bus.mem_rdat != bus.ss_rdat) begin
            state <= ERR;
            err_code <= 2'b01;
          end else begin
            state <= L_RD;
            addr <= 8'h00;
            cnt <= 16'h0000;
          end
        end
        L_RD: begin
          if (cnt == 16'd1) begin
            dout <= bus.mem_rdat;
            tmo <= '0;
            state <= L_WFALL;
          end else cnt <= cnt + 16'd1;
        end
        L_WFALL, L_WRISE: begin
          if (state == L_WFALL ? m2_fall : m2_rise) begin
            tmo <= '0;
            state <= state == L_WFALL ? L_WRISE : L_GAP;
          end else if (tmo_hit) begin
            state <= ERR;
            err_code <= 2'b10;
          end else tmo <= tmo + TW'(1);
        end
        L_GAP: begin
          cnt <= 16'h0000;
          state <= addr == LAST ? DONE : L_RD;
          addr <= addr == LAST ? addr : addr + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ss_seq_ctrl.sv
// tb_ss_seq_ctrl: scoreboard bench with mapper and buffer RAM models for ss_seq_ctrl
module tb_ss_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m2 = 1'b0;
  logic       m2_hold = 1'b0;
  logic       cmd_save = 1'b0;
  logic       cmd_load = 1'b0;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [7:0] map_idx = 8'h23;
  logic [7:0] regs [16];
  logic [7:0] bufm [256] = '{default: 8'h00};
  logic       ld_en = 1'b0;
  logic [7:0] ld_a = 8'h00, ld_d = 8'h00;
  logic [15:0] sb_q[$];
  int n_vec = 0, n_err = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, we_cnt = 0, busy_cyc = 0, stab_viol = 0;
  int wcnt [16] = '{default: 0};
  logic       we_q = 1'b0;
  logic [7:0] addr_q = 8'h00, dout_q = 8'h00;

  ss_seq_if bus();

  ss_seq_ctrl #(.REG_CNT(16), .IDX_ADDR(127), .SETTLE(2), .M2_TMO(1024)) dut (
    .clk(clk), .rst(rst), .m2(m2), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [15:0] got);
    if (sb_q.size() == 0) chk({tag, "_unexpected"}, 32'(got), 32'hFFFF_FFFF);
    else chk(tag, 32'(got), 32'(sb_q.pop_front()));
  endtask

  assign bus.ss_rdat = bus.ss_addr == 8'd127 ? map_idx :
                       bus.ss_addr < 8'd16 ? regs[bus.ss_addr[3:0]] : 8'h00;

  always @(posedge clk) begin
    if (ld_en) bufm[ld_a] <= ld_d;
    else if (bus.mem_we) bufm[bus.mem_addr] <= bus.mem_wdat;
    bus.mem_rdat <= bufm[bus.mem_addr];
  end

  initial forever begin
    repeat (12) @(negedge clk);
    m2 = m2_hold ? 1'b0 : ~m2;
  end

  // mapper model: latches the save-state write on the falling edge of m2
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'hA0 + 8'(i);
    forever begin
      @(negedge m2);
      if (bus.ss_we) begin
        wr_cnt++;
        if (bus.ss_addr < 8'd16) begin
          regs[bus.ss_addr[3:0]] = bus.ss_dout;
          wcnt[bus.ss_addr[3:0]]++;
        end
        sb_pop("map_wr", {bus.ss_addr, bus.ss_dout});
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_we) sb_pop("mem_wr", {bus.mem_addr, bus.mem_wdat});
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy) busy_cyc++;
    if (bus.ss_we && !we_q) we_cnt++;
    if (bus.ss_we && we_q && (bus.ss_addr != addr_q || bus.ss_dout != dout_q)) stab_viol++;
    we_q <= bus.ss_we;
    addr_q <= bus.ss_addr;
    dout_q <= bus.ss_dout;
  end

  task automatic put(input logic [7:0] a, input logic [7:0] d);
    ld_a = a;
    ld_d = d;
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic start_load();
    @(posedge m2);
    @(negedge clk);
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    int c = 0;
    while (!(done || err) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) chk({tag, "_no_end"}, 32'(0), 32'(1));
    @(negedge clk);
  endtask

  task automatic wait_wr(input string tag, input int target, input int maxc);
    int c = 0;
    while (wr_cnt < target && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) chk({tag, "_no_write"}, 32'(wr_cnt), 32'(target));
  endtask

  task automatic push_save();
    for (int i = 0; i < 16; i++) sb_q.push_back({8'(i), regs[i]});
    sb_q.push_back({8'd127, map_idx});
  endtask

  initial begin
    int d0, e0, w0, b0, r0, c;
    int ws [16];
    logic [7:0] snap [16];
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_act", 32'(bus.ss_act), 32'(0));
    chk("rst_flags", 32'({done, err, err_code, bus.ss_we, bus.mem_we}), 32'(0));
    chk("rst_bus", {bus.ss_addr, bus.ss_dout, bus.mem_addr, bus.mem_wdat}, 32'(0));
    rst = 1'b0;
    @(negedge clk);

    push_save();
    d0 = done_cnt; w0 = we_cnt; b0 = busy_cyc;
    cmd_save = 1'b1;
    @(negedge clk);
    cmd_save = 1'b0;
    chk("save_busy", 32'(busy), 32'(1));
    wait_end("save", 300);
    chk("save_done", 32'(done_cnt - d0), 32'(1));
    chk("save_len", 32'(busy_cyc - b0), 32'(68));
    chk("save_we", 32'(we_cnt - w0), 32'(0));
    chk("save_sb", 32'(sb_q.size()), 32'(0));
    chk("save_idx", 32'(bufm[127]), 32'h23);
    chk("save_idle", 32'({busy, bus.ss_act}), 32'(0));

    for (int i = 0; i < 16; i++) begin
      v = ~8'(i);
      put(8'(i), v);
      sb_q.push_back({8'(i), v});
    end
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt; ws = wcnt;
    start_load();
    wait_end("load", 3000);
    chk("load_done", 32'(done_cnt - d0), 32'(1));
    chk("load_err", 32'(err_cnt - e0), 32'(0));
    chk("load_we", 32'(we_cnt - w0), 32'(16));
    chk("load_sb", 32'(sb_q.size()), 32'(0));
    for (int i = 0; i < 16; i++) chk($sformatf("load_once%0d", i), 32'(wcnt[i] - ws[i]), 32'(1));
    chk("load_act", 32'(bus.ss_act), 32'(0));

    put(8'd127, 8'h24);
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    start_load();
    wait_end("idx", 200);
    chk("idx_err", 32'(err_cnt - e0), 32'(1));
    chk("idx_code", 32'(err_code), 32'(2'b01));
    chk("idx_we", 32'(we_cnt - w0), 32'(0));
    chk("idx_done", 32'(done_cnt - d0), 32'(0));
    repeat (5) @(negedge clk);
    chk("idx_code_hold", 32'(err_code), 32'(2'b01));
    put(8'd127, 8'h23);

    for (int i = 0; i < 16; i++) begin
      put(8'(i), 8'h40 + 8'(i));
      if (i < 4) sb_q.push_back({8'(i), 8'h40 + 8'(i)});
    end
    snap = regs;
    e0 = err_cnt; r0 = wr_cnt;
    start_load();
    wait_wr("tmo", r0 + 4, 2000);
    m2_hold = 1'b1;
    c = 0;
    while (!err && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_lat", 32'(c >= 1024 && c <= 1034), 32'(1));
    chk("tmo_code", 32'(err_code), 32'(2'b10));
    @(negedge clk);
    chk("tmo_err", 32'(err_cnt - e0), 32'(1));
    chk("tmo_wr", 32'(wr_cnt - r0), 32'(4));
    chk("tmo_sb", 32'(sb_q.size()), 32'(0));
    for (int i = 4; i < 16; i++) chk($sformatf("tmo_keep%0d", i), 32'(regs[i]), 32'(snap[i]));
    m2_hold = 1'b0;
    repeat (30) @(negedge clk);

    push_save();
    d0 = done_cnt; w0 = we_cnt;
    cmd_save = 1'b1;
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_save = 1'b0;
    cmd_load = 1'b0;
    repeat (5) @(negedge clk);
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    wait_end("both", 300);
    repeat (100) @(negedge clk);
    chk("both_done", 32'(done_cnt - d0), 32'(1));
    chk("both_we", 32'(we_cnt - w0), 32'(0));
    chk("both_sb", 32'(sb_q.size()), 32'(0));
    chk("both_idle", 32'(busy), 32'(0));

    for (int i = 0; i < 16; i++) begin
      put(8'(i), 8'h60 + 8'(i));
      if (i < 8) sb_q.push_back({8'(i), 8'h60 + 8'(i)});
    end
    r0 = wr_cnt;
    start_load();
    wait_wr("rst", r0 + 8, 2000);
    repeat (2) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_act", 32'({busy, bus.ss_act, bus.ss_we}), 32'(0));
    chk("arst_flags", 32'({done, err, err_code, bus.mem_we}), 32'(0));
    chk("arst_bus", {bus.ss_addr, bus.ss_dout, bus.mem_addr, bus.mem_wdat}, 32'(0));
    chk("arst_sb", 32'(sb_q.size()), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_nopulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'(0));

    push_save();
    d0 = done_cnt;
    cmd_save = 1'b1;
    @(negedge clk);
    cmd_save = 1'b0;
    wait_end("resave", 300);
    chk("resave_done", 32'(done_cnt - d0), 32'(1));
    chk("resave_sb", 32'(sb_q.size()), 32'(0));
    chk("we_stable", 32'(stab_viol), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
